// File: rtl/debug_uart_pkg.sv
// Shared types and helpers for the debug UART blocks.
// Holds the receiver state encoding and the bit-timing calculation.
package debug_uart_pkg;

  localparam int FRAME_BITS = 8;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_e;

  typedef struct packed {
    int cpb;   // clocks per bit
    int half;  // clocks to the middle of the start bit
  } bit_timing_t;

  function automatic bit_timing_t calc_bit_timing(input int clk_hz, input int bit_rate);
    bit_timing_t t;
    t.cpb  = clk_hz / bit_rate;
    t.half = t.cpb / 2;
    return t;
  endfunction

endpackage

// File: rtl/debug_uart_rx_fifo.sv
// Small synchronous byte FIFO with an extra pointer bit for full/empty.
// Flags overflow when a push meets a full FIFO with no pop in the same cycle.
module debug_uart_rx_fifo
  import debug_uart_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [FRAME_BITS-1:0] push_data,
  input  logic                  pop,
  output logic [FRAME_BITS-1:0] head,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic [FRAME_BITS-1:0] mem [DEPTH];
  logic                  do_pop;
  logic                  do_push;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign do_pop   = pop && !empty;
  // A pop frees the slot this cycle, so a push into a full FIFO still lands.
  assign do_push  = push && (!full || do_pop);
  assign overflow = push && full && !do_pop;
  assign head     = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      // NOTE: storage is cleared too so rx_data reads a defined 0 out of reset;
      // a deeper FIFO would normally skip this and live with X contents.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/debug_uart_rx.sv
// Debug UART receiver: 8N1, LSB first, with a small receive FIFO and
// sticky overrun / framing error flags.
module debug_uart_rx
  import debug_uart_pkg::*;
#(
  parameter int CLK_HZ     = 28_000_000,
  parameter int BIT_RATE   = 4_000_000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  uart_rxd,
  output logic [FRAME_BITS-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_read,
  output logic                  overrun,
  output logic                  framing_err,
  input  logic                  err_clear
);

  localparam bit_timing_t TIMING = calc_bit_timing(CLK_HZ, BIT_RATE);
  localparam int CPB  = TIMING.cpb;
  localparam int HALF = TIMING.half;
  localparam int CW   = $clog2(CPB);
  localparam int BW   = $clog2(FRAME_BITS);

  localparam logic [CW-1:0] CNT_BIT   = CW'(CPB - 1);
  localparam logic [CW-1:0] CNT_START = CW'(HALF - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(FRAME_BITS - 1);

  logic [1:0]            sync;
  logic                  rxd_s;
  rx_state_e             state;
  logic [CW-1:0]         cnt;
  logic [BW-1:0]         bit_idx;
  logic [FRAME_BITS-1:0] shift;
  logic                  stop_tick;
  logic                  push_req;
  logic                  fe_set;
  logic                  fifo_empty;
  logic                  fifo_overflow;
  logic                  unused_fifo_full;

  always_ff @(posedge clk) begin
    // NOTE: every clocked assignment is non-blocking so all flops see the
    // pre-edge values; blocking here would collapse the two sync stages.
    if (rst) sync <= 2'b11;
    else     sync <= {sync[0], uart_rxd};
  end
  assign rxd_s = sync[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RX_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      unique case (state)
        RX_IDLE: begin
          if (!rxd_s) begin
            state <= RX_START;
            cnt   <= CNT_START;
          end
        end
        RX_START: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (rxd_s) begin
            state <= RX_IDLE;  // line back high at mid-start: treat as glitch
          end else begin
            state   <= RX_DATA;
            cnt     <= CNT_BIT;
            bit_idx <= '0;
          end
        end
        RX_DATA: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            shift   <= {rxd_s, shift[FRAME_BITS-1:1]};
            cnt     <= CNT_BIT;
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == LAST_BIT) state <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
          else           state <= rxd_s ? RX_IDLE : RX_WAIT_HIGH;
        end
        RX_WAIT_HIGH: begin
          if (rxd_s) state <= RX_IDLE;
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

  assign stop_tick = (state == RX_STOP) && (cnt == '0);
  assign push_req  = stop_tick && rxd_s;
  assign fe_set    = stop_tick && !rxd_s;

  debug_uart_rx_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push_req),
    .push_data(shift),
    .pop      (rx_read),
    .head     (rx_data),
    .full     (unused_fifo_full),
    .empty    (fifo_empty),
    .overflow (fifo_overflow)
  );

  assign rx_valid = !fifo_empty;

  // A new error in the same cycle as err_clear must not be lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun     <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      if (fifo_overflow)  overrun <= 1'b1;
      else if (err_clear) overrun <= 1'b0;
      if (fe_set)         framing_err <= 1'b1;
      else if (err_clear) framing_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_debug_uart_rx.sv
// Self-checking bench for debug_uart_rx at default timing (CPB=7, HALF=3).
// Frames are driven bit by bit; a queue scoreboard predicts the FIFO contents.
module tb_debug_uart_rx;

  localparam int CPB   = 7;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       uart_rxd = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_read = 1'b0;
  logic       overrun;
  logic       framing_err;
  logic       err_clear = 1'b0;

  int         n_checks = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         rise_cyc = -1;
  logic       rise_arm = 1'b0;

  logic [7:0] exp_q[$];
  logic       exp_ovr = 1'b0;
  logic       exp_fe = 1'b0;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_valid;
    logic       exp_fe;
  } vec_t;

  vec_t vecs[4];

  debug_uart_rx #(
    .CLK_HZ    (28_000_000),
    .BIT_RATE  (4_000_000),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .uart_rxd   (uart_rxd),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_read    (rx_read),
    .overrun    (overrun),
    .framing_err(framing_err),
    .err_clear  (err_clear)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rise_arm && rx_valid) begin
      rise_cyc = cyc;
      rise_arm = 1'b0;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one frame starting right now (just after an edge). Edge k of the
  // frame is the k-th rising edge after the start bit is applied; the stop
  // sample lands on edge 69 (2 sync + HALF + 9*CPB + 1).
  task automatic send_frame(input logic [7:0] data, input logic stop,
                            input int read_edge, input int clr_edge, input int rst_edge);
    logic [9:0] bits;
    logic [7:0] tmp;
    int         n;
    bits = {stop, data, 1'b0};
    n = 0;
    for (int i = 0; i < 10; i++) begin
      uart_rxd = bits[i];
      for (int j = 0; j < CPB; j++) begin
        rx_read   = (n + 1 == read_edge);
        err_clear = (n + 1 == clr_edge);
        if (rst_edge > 0 && n + 1 >= rst_edge) rst = 1'b1;
        if (rx_read && exp_q.size() > 0) check("pop_head", rx_data, exp_q[0]);
        @(posedge clk);
        n++;
        #1;
        if (rx_read && exp_q.size() > 0) tmp = exp_q.pop_front();
        rx_read   = 1'b0;
        err_clear = 1'b0;
      end
    end
    if (rst_edge > 0) begin
      rst = 1'b0;
      exp_q.delete();
      exp_ovr = 1'b0;
      exp_fe  = 1'b0;
    end else if (stop) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(data);
      else                      exp_ovr = 1'b1;
    end else begin
      exp_fe = 1'b1;
    end
  endtask

  task automatic do_read(input string name);
    if (exp_q.size() == 0) begin
      check({name, "_valid_empty"}, rx_valid, 0);
    end else begin
      check({name, "_valid"}, rx_valid, 1);
      check({name, "_data"}, rx_data, exp_q.pop_front());
    end
    rx_read = 1'b1;
    @(posedge clk);
    #1;
    rx_read = 1'b0;
  endtask

  task automatic clear_errors();
    err_clear = 1'b1;
    @(posedge clk);
    #1;
    err_clear = 1'b0;
    exp_ovr = 1'b0;
    exp_fe  = 1'b0;
  endtask

  initial begin
    int start_cyc;

    vecs[0] = '{8'h00, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{8'hFF, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{8'h81, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{8'h3C, 1'b1, 1'b1, 1'b0};

    // Reset state
    idle(3);
    rst = 1'b0;
    check("rst_valid", rx_valid, 0);
    check("rst_data", rx_data, 8'h00);
    check("rst_overrun", overrun, 0);
    check("rst_framing", framing_err, 0);

    // 0xA5 with latency: rx_valid visible 69 edges after the line falls
    idle(2);
    rise_cyc  = -1;
    rise_arm  = 1'b1;
    start_cyc = cyc;
    send_frame(8'hA5, 1'b1, 0, 0, 0);
    check("a5_latency", rise_cyc - start_cyc, 69);
    do_read("a5");
    check("a5_after_pop_valid", rx_valid, 0);

    // Two-cycle glitch: must not start a frame or flag an error
    uart_rxd = 1'b0;
    idle(2);
    uart_rxd = 1'b1;
    idle(10);
    check("glitch_valid", rx_valid, 0);
    check("glitch_framing", framing_err, 0);

    // Table of single frames
    for (int v = 0; v < 4; v++) begin
      send_frame(vecs[v].data, vecs[v].stop, 0, 0, 0);
      check($sformatf("vec%0d_valid", v), rx_valid, vecs[v].exp_valid);
      check($sformatf("vec%0d_framing", v), framing_err, vecs[v].exp_fe);
      check($sformatf("vec%0d_overrun", v), overrun, 0);
      if (vecs[v].exp_valid) do_read($sformatf("vec%0d", v));
      if (!vecs[v].stop) begin
        uart_rxd = 1'b1;
        idle(4);
        clear_errors();
        check($sformatf("vec%0d_fe_cleared", v), framing_err, 0);
      end
      idle(2);
    end

    // Five back-to-back frames with no reads: fifth overflows
    for (int b = 1; b <= 5; b++) begin
      send_frame(8'(b), 1'b1, 0, 0, 0);
      check($sformatf("ovr_frame%0d", b), overrun, exp_ovr);
    end
    check("ovr_set", overrun, 1);
    for (int r = 0; r < 4; r++) do_read($sformatf("ovr_read%0d", r));
    do_read("ovr_read_empty");
    check("ovr_empty_after_idle_pop", rx_valid, 0);
    clear_errors();
    check("ovr_cleared", overrun, 0);

    // Full FIFO, stop sample coinciding with a pop: accepted, no overrun
    idle(2);
    for (int b = 0; b < 4; b++) send_frame(8'h10 + 8'(b), 1'b1, 0, 0, 0);
    send_frame(8'h14, 1'b1, 69, 0, 0);
    check("coinc_overrun", overrun, 0);
    check("coinc_depth", exp_q.size(), 4);
    for (int r = 0; r < 4; r++) do_read($sformatf("coinc_read%0d", r));
    check("coinc_drained", rx_valid, 0);

    // Break: stop low then line held low; one error, err_clear alone clears
    send_frame(8'h00, 1'b0, 0, 0, 0);
    check("brk_framing", framing_err, 1);
    idle(20);
    err_clear = 1'b1;
    idle(1);
    err_clear = 1'b0;
    exp_fe = 1'b0;
    check("brk_clear", framing_err, 0);
    idle(30);
    uart_rxd = 1'b1;
    idle(10);
    check("brk_no_second", framing_err, 0);
    check("brk_no_byte", rx_valid, 0);

    // New framing error in the same cycle as err_clear: set wins
    send_frame(8'h00, 1'b0, 0, 69, 0);
    uart_rxd = 1'b1;
    idle(5);
    check("clr_vs_set", framing_err, 1);
    check("clr_vs_set_no_byte", rx_valid, 0);
    clear_errors();

    // Reset mid-frame (from bit 4 to frame end) with a byte already queued
    send_frame(8'h77, 1'b1, 0, 0, 0);
    check("pre_rst_valid", rx_valid, 1);
    send_frame(8'h99, 1'b1, 0, 0, 38);
    idle(1);
    check("midrst_valid", rx_valid, 0);
    check("midrst_data", rx_data, 8'h00);
    check("midrst_overrun", overrun, 0);
    check("midrst_framing", framing_err, 0);
    send_frame(8'h3C, 1'b1, 0, 0, 0);
    do_read("post_rst");
    check("post_rst_empty", rx_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/debug_uart_rx.md
# debug_uart_rx

Debug UART receiver, the receive-side counterpart of the debug UART transmitter. It synchronizes an asynchronous serial line and decodes 8N1 frames, LSB first. Received bytes go into a small FIFO that the CPU drains through the peripheral read path. Framing and overrun errors are reported as sticky status flags.

## Interface
- CLK_HZ, default 28_000_000: system clock frequency in Hz.
- BIT_RATE, default 4_000_000: serial bit rate. CPB = CLK_HZ/BIT_RATE, integer division; CPB must be ≥ 4. HALF = CPB/2, floored.
- FIFO_DEPTH, default 4: FIFO entries. Must be a power of 2, ≥ 2.
- clk, input, 1: single clock; all state updates on its rising edge.
- rst, input, 1: synchronous, active-high reset.
- uart_rxd, input, 1: asynchronous serial line; idles high.
- rx_data, output, 8: byte at the FIFO head. Meaningful only when rx_valid is 1.
- rx_valid, output, 1: FIFO not empty.
- rx_read, input, 1: one-cycle pop strobe.
- overrun, output, 1: sticky; a byte was dropped because the FIFO was full.
- framing_err, output, 1: sticky; the stop bit was sampled low.
- err_clear, input, 1: one-cycle pulse that clears both sticky flags.

## Operation
- uart_rxd passes through a 2-flop synchronizer to give rxd_s.
- State machine: IDLE, START, DATA, STOP, WAIT_HIGH. A down-counter cnt is wide enough for CPB-1. A 3-bit bit index and an 8-bit shift register complete the datapath.
- IDLE: when rxd_s is 0, go to START and set cnt = HALF-1.
- START: cnt decrements each cycle. When cnt = 0, sample rxd_s.
  - Sample 0: go to DATA with cnt = CPB-1 and bit index 0.
  - Sample 1: the low pulse was a glitch; return to IDLE. No flag is set.
- DATA: each time cnt reaches 0, shift rxd_s into bit 7 (shift right), reload cnt = CPB-1 and increment the bit index. After bit index 7 is sampled, go to STOP.
- STOP: when cnt = 0, sample rxd_s.
  - Sample 1: push the shift register into the FIFO and go to IDLE. If the FIFO is full and there is no pop in the same cycle, drop the byte, set overrun, and leave the FIFO unchanged.
  - Sample 0: set framing_err, discard the byte, and go to WAIT_HIGH.
- WAIT_HIGH: stay until rxd_s is 1, then go to IDLE. A held break therefore yields exactly one framing error and no bytes.
- FIFO:
  - rx_read while empty is ignored.
  - Push and pop in the same cycle are both honoured: when full, no overrun; when empty, the pop is ignored and the push proceeds.
  - Pointers wrap modulo FIFO_DEPTH. An extra pointer bit distinguishes full from empty.
- Flags: err_clear clears both flags. If a set and err_clear occur in the same cycle, the set wins.
- Reset values: state IDLE, cnt 0, shift register 0, FIFO empty with all storage 0, rx_data 0, rx_valid 0, overrun 0, framing_err 0, synchronizer flops 1.
- Reset asserted mid-frame abandons the frame. No byte is pushed and no flag is set.

## Timing
- rxd_s lags uart_rxd by 2 cycles.
- T0 is the first cycle in which rxd_s = 0 while in IDLE. Start sample occurs at T0+HALF, data bit k at T0+HALF+(k+1)·CPB, stop sample at T0+HALF+9·CPB.
- The push is registered at the stop sample. rx_valid and rx_data update in the following cycle.
- rx_data and rx_valid are combinational from FIFO state. A pop at cycle N exposes the next entry at N+1.
- The next frame may start immediately. IDLE detects a start bit in the cycle after the return from STOP, so back-to-back frames at full rate are received.

## Structure
- Package debug_uart_pkg holds:
  - the rx state enum (IDLE, START, DATA, STOP, WAIT_HIGH);
  - a function computing CPB and HALF from CLK_HZ and BIT_RATE;
  - FRAME_BITS = 8.
- Sub-module debug_uart_rx_fifo: synchronous FIFO, 8 bits wide, FIFO_DEPTH deep. It exposes push, pop, full, empty and head. It produces the overrun condition and is reused by any later buffered peripheral.
- The top level holds the synchronizer, state machine and sticky flags.

## Test plan
All scenarios use defaults: CPB = 7, HALF = 3.
- Frame 0xA5 (line bits 0,1,0,1,0,0,1,0,1 then stop 1) → rx_valid rises at T0+67 with rx_data = 0xA5. One rx_read → rx_valid = 0 next cycle.
- 2-cycle low glitch on uart_rxd → no push, framing_err = 0, state back to IDLE by T0+4.
- Bytes 0x01..0x05 sent back to back with no reads → FIFO holds 0x01..0x04 and overrun = 1. Four reads return 0x01, 0x02, 0x03, 0x04 in order.
- FIFO full with a stop sample coinciding with rx_read → byte accepted, overrun stays 0, FIFO remains full.
- Stop bit low, then the line held low 50 cycles → framing_err = 1, no push, no second framing error. err_clear pulsed alone → framing_err = 0. err_clear coinciding with a new framing error → flag stays 1.
- rst asserted at bit 4 of a frame → all outputs return to reset values, no byte appears. The following clean frame 0x3C is received correctly.
